ctrl_fsm: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 9-bit ISA core. It owns the PC and the instruction register (ir, which feeds the instruction decoder). It resolves conditional and unconditional jumps, issues the register-file and flag write enables, and runs a request/ready handshake to data memory for loads and stores. It sits between the synchronous instruction ROM, the jump-target LUT, the ALU flag register and data memory.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_class.sv | 40 ++++
 rtl/ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_ctrl_fsm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and opcode patterns for the 9-bit ISA control sequencer.
package cpu_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OP_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    JK_NONE,
    JK_GT,
    JK_GE,
    JK_ALWAYS
  } jump_kind_t;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  // Class patterns over ir[8:4]; '?' bits are don't-care in casez.
  localparam logic [OP_W-1:0] PAT_ALU2    = 5'b00???;
  localparam logic [OP_W-1:0] PAT_ALU2S   = 5'b01???;
  localparam logic [OP_W-1:0] PAT_ALU1_A  = 5'b1010?;
  localparam logic [OP_W-1:0] PAT_ALU1_B  = 5'b10110;
  localparam logic [OP_W-1:0] PAT_JCOND   = 5'b1000?;
  localparam logic [OP_W-1:0] PAT_JMP     = 5'b10010;
  localparam logic [OP_W-1:0] PAT_MEM_REG = 5'b10111;
  localparam logic [OP_W-1:0] PAT_MEM_IMM = 5'b11000;

endpackage

// File: rtl/instr_class.sv
// Combinational instruction classifier: ir[8:3] -> write enables, memory kind, jump kind.
module instr_class
  import cpu_pkg::*;
(
  input  logic [5:0]  op_i,
  output logic        wr_reg_c,
  output logic        wr_flag_c,
  output logic        is_mem_c,
  output logic        is_store_c,
  output jump_kind_t  jump_c
);

  always_comb begin
    wr_reg_c   = 1'b0;
    wr_flag_c  = 1'b0;
    is_mem_c   = 1'b0;
    is_store_c = 1'b0;
    jump_c     = JK_NONE;
    casez (op_i[5:1])
      // ir[6] selects cmp (flags only) over mov (register only)
      PAT_ALU2: begin
        wr_reg_c  = ~op_i[3];
        wr_flag_c = op_i[3];
      end
      PAT_ALU2S, PAT_ALU1_A, PAT_ALU1_B: begin
        wr_reg_c  = 1'b1;
        wr_flag_c = 1'b1;
      end
      PAT_JCOND:   jump_c = op_i[1] ? JK_GE : JK_GT;
      PAT_JMP:     jump_c = JK_ALWAYS;
      PAT_MEM_REG: begin
        is_mem_c   = 1'b1;
        is_store_c = op_i[0];
      end
      PAT_MEM_IMM: is_mem_c = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute sequencer: owns pc and ir, resolves jumps, drives
// register/flag write enables and the data-memory request/ready handshake.
module ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         instr,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               flag_gt,
  input  logic               flag_eq,
  input  logic               mem_ready,
  output logic [PC_W-1:0]    pc,
  output logic [8:0]         ir,
  output logic               reg_we,
  output logic               flag_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic               done,
  output logic [CNT_W-1:0]   retired
);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 reg_we_q, reg_we_d;
  logic                 flag_we_q, flag_we_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic                 done_q, done_d;

  logic                 dec_wr_reg_c;
  logic                 dec_wr_flag_c;
  logic                 dec_is_mem_c;
  logic                 dec_is_store_c;
  jump_kind_t           dec_jump_c;
  logic                 taken_c;
  logic                 retire_c;

  // ir only loads in DECODE; kept separate so the decoder sees the next ir without a comb loop
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_DECODE) begin
      ir_d = instr;
    end
  end

  instr_class u_instr_class (
    .op_i       (ir_d[8:3]),
    .wr_reg_c   (dec_wr_reg_c),
    .wr_flag_c  (dec_wr_flag_c),
    .is_mem_c   (dec_is_mem_c),
    .is_store_c (dec_is_store_c),
    .jump_c     (dec_jump_c)
  );

  always_comb begin
    case (dec_jump_c)
      JK_GT:     taken_c = flag_gt;
      JK_GE:     taken_c = flag_gt | flag_eq;
      JK_ALWAYS: taken_c = 1'b1;
      default:   taken_c = 1'b0;
    endcase
  end

  // Next-state, pc and retire counter; enables are registered from the next state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    retire_c  = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (instr == HALT_INSTR) ? ST_HALTED : ST_EXEC;
      ST_EXEC: begin
        if (dec_is_mem_c) begin
          state_d = ST_MEM_WAIT;
        end else begin
          state_d  = ST_FETCH;
          retire_c = 1'b1;
          pc_d     = taken_c ? jump_target : pc_q + PC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          pc_d = pc_q + PC_W'(1);
          if (dec_is_store_c) begin
            state_d  = ST_FETCH;
            retire_c = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (retire_c && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end

    reg_we_d  = ((state_d == ST_EXEC) && dec_wr_reg_c) || (state_d == ST_WB);
    flag_we_d = (state_d == ST_EXEC) && dec_wr_flag_c;
    mem_req_d = (state_d == ST_MEM_WAIT);
    mem_we_d  = (state_d == ST_MEM_WAIT) && dec_is_store_c;
    done_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      reg_we_q  <= 1'b0;
      flag_we_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      reg_we_q  <= reg_we_d;
      flag_we_q <= flag_we_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      done_q    <= done_d;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;
  assign reg_we  = reg_we_q;
  assign flag_we = flag_we_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: vector table, corner sequences, random programs
// against an instruction-level model, and a narrow instance for wrap/saturation.
module tb_ctrl_fsm;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;
  localparam logic [8:0]  HALT  = 9'h1FF;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [8:0]       instr;
  logic [PC_W-1:0]  jump_target;
  logic             flag_gt, flag_eq;
  logic             mem_ready;
  logic [PC_W-1:0]  pc;
  logic [8:0]       ir;
  logic             reg_we, flag_we, mem_req, mem_we, done;
  logic [CNT_W-1:0] retired;

  logic             start_s;
  logic [3:0]       pc_s;
  logic [8:0]       ir_s;
  logic             reg_we_s, flag_we_s, mem_req_s, mem_we_s, done_s;
  logic [2:0]       retired_s;

  logic [8:0]       rom [1024];
  logic [PC_W-1:0]  lut [16];

  int checks = 0;
  int errors = 0;
  int n_reg = 0, n_flag = 0, n_req = 0, n_we = 0;
  int mem_wait_n = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  ctrl_fsm #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .jump_target(jump_target), .flag_gt(flag_gt), .flag_eq(flag_eq),
    .mem_ready(mem_ready), .pc(pc), .ir(ir), .reg_we(reg_we),
    .flag_we(flag_we), .mem_req(mem_req), .mem_we(mem_we), .done(done),
    .retired(retired)
  );

  ctrl_fsm #(.PC_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .instr(9'h1C0),
    .jump_target(4'h0), .flag_gt(1'b0), .flag_eq(1'b0),
    .mem_ready(1'b0), .pc(pc_s), .ir(ir_s), .reg_we(reg_we_s),
    .flag_we(flag_we_s), .mem_req(mem_req_s), .mem_we(mem_we_s), .done(done_s),
    .retired(retired_s)
  );

  // Synchronous instruction ROM and combinational jump LUT
  always @(posedge clk) instr <= rom[pc];
  assign jump_target = lut[ir[3:0]];

  // Memory responder: ready after mem_wait_n wait cycles of an active request
  assign mem_ready = mem_req && (req_cnt == mem_wait_n);
  always @(posedge clk) req_cnt <= (mem_req && !mem_ready) ? req_cnt + 1 : 0;

  always @(negedge clk) begin
    if (reg_we)  n_reg  <= n_reg + 1;
    if (flag_we) n_flag <= n_flag + 1;
    if (mem_req) n_req  <= n_req + 1;
    if (mem_req && mem_we) n_we <= n_we + 1;
  end

  typedef struct {
    logic [8:0] ins;
    logic       gt;
    logic       eq;
    int         w;
    int         cyc;
    logic [9:0] epc;
    int         nreg;
    int         nflag;
    int         nreq;
    int         nwe;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH for cyc cycles and checks its effects
  task automatic step_check(input string tag, input int cyc, input logic [9:0] epc,
                            input int eret, input int er, input int ef,
                            input int erq, input int ew);
    int b_r, b_f, b_q, b_w;
    b_r = n_reg; b_f = n_flag; b_q = n_req; b_w = n_we;
    repeat (cyc) @(posedge clk);
    #1;
    chk({tag, "_pc"},      32'(pc), 32'(epc));
    chk({tag, "_retired"}, 32'(retired), 32'(eret));
    chk({tag, "_reg_we"},  32'(n_reg - b_r), 32'(er));
    chk({tag, "_flag_we"}, 32'(n_flag - b_f), 32'(ef));
    chk({tag, "_mem_req"}, 32'(n_req - b_q), 32'(erq));
    chk({tag, "_mem_we"},  32'(n_we - b_w), 32'(ew));
  endtask

  // Instruction-level reference: effects of one instruction from the ISA rules
  function automatic void model(input logic [8:0] in, input logic gt, input logic eq,
                                input int w, input logic [9:0] cur, input logic [9:0] tgt,
                                output int cyc, output int nr, output int nf,
                                output int nq, output int nw, output logic [9:0] npc);
    int   op;
    logic taken, is_mem, is_st;
    op = int'(in[8:4]);
    taken = 1'b0; is_mem = 1'b0; is_st = 1'b0;
    nr = 0; nf = 0; nq = 0; nw = 0;
    if (in[8:7] == 2'b00) begin
      if (in[6]) nf = 1; else nr = 1;
    end else if (in[8:7] == 2'b01 || op == 20 || op == 21 || op == 22) begin
      nr = 1; nf = 1;
    end else if (op == 16) taken = gt;
    else if (op == 17) taken = gt | eq;
    else if (op == 18) taken = 1'b1;
    else if (op == 23) begin is_mem = 1'b1; is_st = in[3]; end
    else if (op == 24) is_mem = 1'b1;
    if (is_mem) begin
      nq  = w + 1;
      nw  = is_st ? w + 1 : 0;
      nr  = is_st ? 0 : 1;
      cyc = is_st ? 4 + w : 5 + w;
      npc = cur + 10'd1;
    end else begin
      cyc = 3;
      npc = taken ? tgt : cur + 10'd1;
    end
  endfunction

  initial begin
    int cyc, nr, nf, nq, nw;
    logic [9:0] m_pc, npc;
    int m_ret;
    logic [8:0] cur;
    logic g, e;
    int w;

    vecs[0]  = '{9'h00A, 1'b0, 1'b0, 0, 3, 10'h001, 1, 0, 0, 0};
    vecs[1]  = '{9'h04A, 1'b0, 1'b0, 0, 3, 10'h001, 0, 1, 0, 0};
    vecs[2]  = '{9'h0A5, 1'b0, 1'b0, 0, 3, 10'h001, 1, 1, 0, 0};
    vecs[3]  = '{9'h14A, 1'b0, 1'b0, 0, 3, 10'h001, 1, 1, 0, 0};
    vecs[4]  = '{9'h16A, 1'b0, 1'b0, 0, 3, 10'h001, 1, 1, 0, 0};
    vecs[5]  = '{9'h105, 1'b1, 1'b0, 0, 3, 10'h020, 0, 0, 0, 0};
    vecs[6]  = '{9'h105, 1'b0, 1'b1, 0, 3, 10'h001, 0, 0, 0, 0};
    vecs[7]  = '{9'h115, 1'b0, 1'b1, 0, 3, 10'h020, 0, 0, 0, 0};
    vecs[8]  = '{9'h115, 1'b0, 1'b0, 0, 3, 10'h001, 0, 0, 0, 0};
    vecs[9]  = '{9'h125, 1'b0, 1'b0, 0, 3, 10'h020, 0, 0, 0, 0};
    vecs[10] = '{9'h173, 1'b0, 1'b0, 2, 7, 10'h001, 1, 0, 3, 0};
    vecs[11] = '{9'h17B, 1'b0, 1'b0, 0, 4, 10'h001, 0, 0, 1, 1};
    vecs[12] = '{9'h180, 1'b0, 1'b0, 0, 5, 10'h001, 1, 0, 1, 0};
    vecs[13] = '{9'h1C0, 1'b1, 1'b1, 0, 3, 10'h001, 0, 0, 0, 0};
    vecs[14] = '{9'h135, 1'b1, 1'b0, 0, 3, 10'h001, 0, 0, 0, 0};
    vecs[15] = '{9'h17F, 1'b0, 1'b0, 1, 5, 10'h001, 0, 0, 2, 2};

    for (int i = 0; i < 1024; i++) rom[i] = HALT;
    for (int i = 0; i < 16; i++) lut[i] = 10'h020;
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    flag_gt = 1'b0; flag_eq = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_outs", 32'({reg_we, flag_we, mem_req, mem_we, done}), 32'h0);

    for (int i = 0; i < 16; i++) begin
      rom[0] = vecs[i].ins;
      flag_gt = vecs[i].gt; flag_eq = vecs[i].eq; mem_wait_n = vecs[i].w;
      do_start();
      step_check($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].epc, 1,
                 vecs[i].nreg, vecs[i].nflag, vecs[i].nreq, vecs[i].nwe);
      chk($sformatf("vec%0d_ir", i), 32'(ir), 32'(vecs[i].ins));
      chk($sformatf("vec%0d_done_pre", i), 32'(done), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done", i), 32'(done), 32'h1);
      chk($sformatf("vec%0d_halt_pc", i), 32'(pc), 32'(vecs[i].epc));
      chk($sformatf("vec%0d_halt_ret", i), 32'(retired), 32'h1);
    end

    // start held high through a whole instruction must not restart it
    rom[0] = 9'h00A;
    do_start();
    start = 1'b1;
    step_check("start_ignored", 3, 10'h001, 1, 1, 0, 0, 0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("start_ignored_done", 32'(done), 32'h1);

    // Asynchronous reset in the middle of a memory handshake
    rom[0] = 9'h00A; rom[1] = 9'h173; rom[2] = HALT;
    mem_wait_n = 1000;
    do_start();
    repeat (6) @(posedge clk);
    #1;
    chk("mw_req", 32'(mem_req), 32'h1);
    chk("mw_pc", 32'(pc), 32'h1);
    chk("mw_ret", 32'(retired), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_ret", 32'(retired), 32'h0);
    chk("arst_outs", 32'({reg_we, flag_we, mem_we, done}), 32'h0);
    @(negedge clk) reset = 1'b0;
    mem_wait_n = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_pc", 32'(pc), 32'h0);
    chk("idle_outs", 32'({reg_we, flag_we, mem_req, done}), 32'h0);

    // Random programs against the instruction-level model
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
    for (int i = 0; i < 16; i++) lut[i] = 10'($urandom_range(0, 1023));
    do_start();
    m_pc = '0; m_ret = 0;
    for (int k = 0; k < 250; k++) begin
      cur = rom[m_pc];
      g = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      w = int'($urandom_range(0, 3));
      flag_gt = g; flag_eq = e; mem_wait_n = w;
      model(cur, g, e, w, m_pc, lut[cur[3:0]], cyc, nr, nf, nq, nw, npc);
      m_ret++;
      m_pc = npc;
      step_check($sformatf("rnd%0d", k), cyc, m_pc, m_ret, nr, nf, nq, nw);
    end
    flag_gt = 1'b0; flag_eq = 1'b0; mem_wait_n = 0;

    // Narrow instance: pc wraps at 16, retired saturates at 7
    @(negedge clk) start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("small%0d_pc", k), 32'(pc_s), 32'(k % 16));
      chk($sformatf("small%0d_ret", k), 32'(retired_s), 32'((k > 7) ? 7 : k));
      chk($sformatf("small%0d_ir", k), 32'(ir_s), 32'h1C0);
      chk($sformatf("small%0d_outs", k),
          32'({reg_we_s, flag_we_s, mem_req_s, mem_we_s, done_s}), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
